// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that funnels several read requesters onto one AXI read port.
// Only one burst is in flight at a time, and beats are steered back to the granted requester.
module axi_rd_arbiter #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CW     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*8-1:0]      req_len,
    input  logic [NUM_CH-1:0]        req_uncached,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_last,
    output logic                     rsp_err,
    output logic [3:0]               arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [2:0] SIZE   = 3'($clog2(DATA_W / 8));

    logic [1:0]        state;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic              unc_q;
    logic              arvalid_q;
    logic [7:0]        beat;

    logic              gnt_any;
    logic [CW-1:0]     gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic [3:0]        id_g;
    logic              beat_v;
    logic              unused;

    // Channel reached k steps above the round-robin pointer, wrapping at NUM_CH.
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CW'(s);
    endfunction

    // Pick the first requesting channel at or above rr_ptr (lowest offset wins).
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(rr_ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(rr_ptr, k);
            end
        end
    end

    assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_len  = req_len[gnt_idx*8 +: 8];
    assign id_g     = {{(4 - CW){1'b0}}, gnt};
    assign beat_v   = rvalid & rready;
    assign unused   = ^{rresp[0], sel_addr[ADDR_W-1 -: 3]};

    // Transaction sequencer: grant, issue the address, then count data beats.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            unc_q     <= 1'b0;
            arvalid_q <= 1'b0;
            beat      <= '0;
            req_ready <= '0;
        end else begin
            req_ready <= '0;
            unique case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        req_ready <= NUM_CH'(1) << gnt_idx;
                        gnt       <= gnt_idx;
                        addr_q    <= {3'b000, sel_addr[ADDR_W-4:0]};
                        len_q     <= sel_len;
                        unc_q     <= req_uncached[gnt_idx];
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                    end else if (arready) begin
                        arvalid_q <= 1'b0;
                        beat      <= '0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rvalid) begin
                        if (beat != 8'hFF) beat <= beat + 8'd1;
                        if (rlast) begin
                            state  <= S_IDLE;
                            rr_ptr <= (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arid    = id_g;
    assign arsize  = arvalid_q ? SIZE : 3'b000;
    assign arburst = arvalid_q ? 2'b01 : 2'b00;
    assign arcache = (arvalid_q && !unc_q) ? 4'hF : 4'h0;
    assign arlock  = 2'b00;
    assign arprot  = 3'b000;

    assign rready    = (state == S_DATA);
    assign rsp_valid = beat_v ? (NUM_CH'(1) << gnt) : '0;
    assign rsp_data  = beat_v ? rdata : '0;
    assign rsp_last  = beat_v & rlast;
    assign rsp_err   = beat_v & (rresp[1] | (rid != id_g) | (rlast != (beat == len_q)));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter.
// Expected grants, AR beats and response beats are queued, and a negedge monitor checks them.
module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic [N-1:0]  req_uncached;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic [3:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [1:0]    arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [3:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_uncached(req_uncached),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    typedef struct packed {
        logic [2:0]  v;
        logic [31:0] d;
        logic        l;
        logic        e;
    } rsp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [3:0]  cache;
    } ar_t;

    logic [2:0] q_gnt[$];
    ar_t        q_ar[$];
    rsp_t       q_rsp[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_cyc = -100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a grant, an AR handshake or a beat.
    always @(negedge clk) begin
        ar_t  ea;
        rsp_t er;
        cyc++;
        if (resetn) begin
            if (req_ready != '0) begin
                if (q_gnt.size() == 0) chk("gnt_unexpected", 64'(req_ready), 64'd0);
                else chk("gnt", 64'(req_ready), 64'(q_gnt.pop_front()));
                if (last_cyc >= 0) chk("idle_gap", 64'(cyc - last_cyc >= 2), 64'd1);
            end
            if (arvalid && arready) begin
                if (q_ar.size() == 0) begin
                    chk("ar_unexpected", 64'(arvalid), 64'd0);
                end else begin
                    ea = q_ar.pop_front();
                    chk("ar", {6'd0, araddr, arid, arlen, arcache, arsize, arburst, arlock, arprot},
                        {6'd0, ea.a, ea.id, ea.len, ea.cache, 3'd2, 2'b01, 2'b00, 3'b000});
                end
            end
            if (rsp_valid != '0) begin
                if (q_rsp.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    er = q_rsp.pop_front();
                    chk("rsp", 64'({rsp_valid, rsp_data, rsp_last, rsp_err}), 64'(er));
                end
                if (rsp_last) last_cyc = cyc;
            end
        end
    end

    // Raise a request, drop it once accepted and measure cycles until arvalid.
    task automatic request(input int ch, input logic [31:0] a, input logic [7:0] len,
                           input logic unc, input logic [31:0] exp_a);
        int   lat;
        ar_t  e;
        e.a = exp_a;
        e.id = 4'(ch);
        e.len = len;
        e.cache = unc ? 4'h0 : 4'hF;
        q_gnt.push_back(3'(1 << ch));
        q_ar.push_back(e);
        req_addr[ch*32 +: 32] = a;
        req_len[ch*8 +: 8] = len;
        req_uncached[ch] = unc;
        req_valid[ch] = 1'b1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[ch]) req_valid[ch] = 1'b0;
            if (arvalid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 64'(lat), 64'd2);
    endtask

    // Act as the AXI slave: optional arready stall, then len+1 beats with injected faults.
    task automatic serve(input int ch, input int len, input int ar_delay, input int err_beat,
                         input int early_beat, input int abort_beat, input logic [31:0] base);
        int          n;
        logic        last;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [3:0]  i0;
        rsp_t        e;
        n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arvalid_seen", 64'(arvalid), 64'd1);
        a0 = araddr;
        l0 = arlen;
        i0 = arid;
        for (int i = 0; i < ar_delay; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("ar_hold", {19'd0, arvalid, rready, araddr, arlen, arid}, {19'd0, 1'b1, 1'b0, a0, l0, i0});
        end
        @(posedge clk);
        #1 arready = 1'b1;
        @(posedge clk);
        #1 arready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            last = (b == len) || (b == early_beat);
            rvalid = 1'b1;
            rid = 4'(ch);
            rdata = base + 32'(b);
            rresp = (b == err_beat) ? 2'b10 : 2'b00;
            rlast = last;
            if (b == abort_beat) begin
                #1 resetn = 1'b0;
                #1 chk("abort_outputs",
                       64'({rsp_valid, rsp_last, rsp_err, rready, arvalid, req_ready, rsp_data}), 64'd0);
                rvalid = 1'b0;
                rlast = 1'b0;
                rresp = 2'b00;
                return;
            end
            e.v = 3'(1 << ch);
            e.d = base + 32'(b);
            e.l = last;
            e.e = (b == err_beat) || (last != (b == len));
            q_rsp.push_back(e);
            @(posedge clk);
            #1;
            if (last) break;
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
        if (early_beat >= 0) begin
            @(negedge clk);
            chk("idle_after_early", 64'({rready, rsp_valid}), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ar_t e;
        req_valid = '0;
        req_addr = '0;
        req_len = '0;
        req_uncached = '0;
        arready = 1'b0;
        rid = '0;
        rdata = '0;
        rresp = '0;
        rlast = 1'b0;
        rvalid = 1'b0;
        #22 resetn = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            64'({req_ready, arvalid, rready, rsp_valid, rsp_last, rsp_err, araddr, arlen}), 64'd0);
        @(posedge clk);
        #1;

        // Fairness: all three held, expect 0,1,2,0.
        req_addr = {32'h8000_2000, 32'h8000_1000, 32'h8000_0000};
        req_len = '0;
        req_uncached = '0;
        q_gnt.push_back(3'b001);
        q_gnt.push_back(3'b010);
        q_gnt.push_back(3'b100);
        q_gnt.push_back(3'b001);
        e.len = 8'd0;
        e.cache = 4'hF;
        e.a = 32'h0000_0000; e.id = 4'd0; q_ar.push_back(e);
        e.a = 32'h0000_1000; e.id = 4'd1; q_ar.push_back(e);
        e.a = 32'h0000_2000; e.id = 4'd2; q_ar.push_back(e);
        e.a = 32'h0000_0000; e.id = 4'd0; q_ar.push_back(e);
        req_valid = 3'b111;
        serve(0, 0, 0, -1, -1, -1, 32'h1111_0000);
        serve(1, 0, 0, -1, -1, -1, 32'h2222_0000);
        serve(2, 0, 0, -1, -1, -1, 32'h3333_0000);
        @(posedge clk);
        #1 req_valid = '0;
        serve(0, 0, 0, -1, -1, -1, 32'h4444_0000);

        // Single uncached beat on ch1.
        request(1, 32'h9FC0_0100, 8'd0, 1'b1, 32'h1FC0_0100);
        serve(1, 0, 0, -1, -1, -1, 32'hCAFE_0000);

        // Cached 8-beat burst on ch0.
        request(0, 32'h8000_0040, 8'd7, 1'b0, 32'h0000_0040);
        serve(0, 7, 0, -1, -1, -1, 32'hB000_0000);

        // SLVERR on beat 2 of a 4-beat burst.
        request(2, 32'hA000_0200, 8'd3, 1'b0, 32'h0000_0200);
        serve(2, 3, 0, 2, -1, -1, 32'hE000_0000);

        // Early rlast on beat 1 of a 4-beat burst.
        request(1, 32'h8000_0300, 8'd3, 1'b1, 32'h0000_0300);
        serve(1, 3, 0, -1, 1, -1, 32'hD000_0000);

        // arready stalled for 5 cycles.
        request(2, 32'hBFC0_0400, 8'd1, 1'b1, 32'h1FC0_0400);
        serve(2, 1, 5, -1, -1, -1, 32'hF000_0000);

        // Reset during beat 3, then a fresh request on ch2.
        request(1, 32'h8000_0500, 8'd7, 1'b0, 32'h0000_0500);
        serve(1, 7, 0, -1, -1, 3, 32'h5000_0000);
        #10 resetn = 1'b1;
        @(posedge clk);
        #1;
        request(2, 32'h8000_0600, 8'd0, 1'b0, 32'h0000_0600);
        serve(2, 0, 0, -1, -1, -1, 32'h6000_0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", 64'(q_gnt.size() + q_ar.size() + q_rsp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
